// File: rtl/pw_md4_block_pkg.sv
// Shared constants and state encoding for the password-to-MD4-block formatter.
//   MAX_CHARS_DEF  : default maximum password length in characters
//   MD4_BLOCK_BITS : width of one MD4 message block
//   MD4_WORDS      : 32-bit words per block
//   PAD_BYTE       : first padding byte following the message
//   state_t        : IDLE (accepting), BUILD (writing words), HOLD (presenting block)
package pw_md4_block_pkg;

    localparam int         MAX_CHARS_DEF  = 20;
    localparam int         MD4_BLOCK_BITS = 512;
    localparam int         MD4_WORDS      = 16;
    localparam logic [7:0] PAD_BYTE       = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/pw_md4_word.sv
// Combinational generator for one 32-bit word of the NT-hash MD4 block.
//   password : latched password, char i at [PW_WIDTH-1-8*i -: 8]
//   length   : latched character count L
//   word_idx : word number w (0..15)
//   word     : bytes 4w..4w+3, byte 4w+k in bits 8k+7:8k
// Byte b rules: UTF-16LE chars for b < 2L, 0x80 at b == 2L, bit length 16*L in
// bytes 56/57, zero elsewhere.
module pw_md4_word
    import pw_md4_block_pkg::*;
#(
    parameter  int MAX_CHARS = MAX_CHARS_DEF,
    localparam int PW_WIDTH  = 8 * MAX_CHARS
) (
    input  logic [PW_WIDTH-1:0] password,
    input  logic [5:0]          length,
    input  logic [3:0]          word_idx,
    output logic [31:0]         word
);

    // Character table padded to 32 entries so any 5-bit char index is in range.
    logic [7:0]  chars [32];
    logic [15:0] bit_len;
    logic [6:0]  two_l;

    assign bit_len = {6'd0, length, 4'd0};
    assign two_l   = {length, 1'b0};

    genvar i;
    for (i = 0; i < 32; i++) begin : g_chars
        if (i < MAX_CHARS) begin : g_used
            assign chars[i] = password[PW_WIDTH-1-8*i -: 8];
        end else begin : g_unused
            assign chars[i] = 8'h00;
        end
    end

    genvar k;
    for (k = 0; k < 4; k++) begin : g_byte
        logic [5:0] b;
        logic [7:0] val;

        assign b = {word_idx, 2'(k)};

        always_comb begin
            val = 8'h00;
            if ({1'b0, b} < two_l)
                val = b[0] ? 8'h00 : chars[b[5:1]];
            else if ({1'b0, b} == two_l)
                val = PAD_BYTE;
            else if (b == 6'd56)
                val = bit_len[7:0];
            else if (b == 6'd57)
                val = bit_len[15:8];
        end

        assign word[8*k +: 8] = val;
    end

endmodule

// File: rtl/pw_md4_block.sv
// Formats one candidate password into the single 512-bit MD4 block for the NT hash.
//   clk, reset        : clock, asynchronous active-high reset
//   in_password       : candidate, char 0 in the MSB byte
//   in_length         : number of valid characters
//   in_valid/in_ready : upstream handshake (in_ready only in IDLE)
//   out_block         : MD4 block, word w at [32w+31:32w]
//   out_error         : length exceeded MAX_CHARS (block is all zero)
//   out_valid/out_ready : downstream handshake; block held until accepted
// The block is written one word per cycle over 16 cycles after the transfer.
module pw_md4_block
    import pw_md4_block_pkg::*;
#(
    parameter  int MAX_CHARS = MAX_CHARS_DEF,
    localparam int PW_WIDTH  = 8 * MAX_CHARS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PW_WIDTH-1:0]       in_password,
    input  logic [5:0]                in_length,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MD4_BLOCK_BITS-1:0] out_block,
    output logic                      out_error,
    output logic                      out_valid,
    input  logic                      out_ready
);

    state_t              state;
    logic [3:0]          w;
    logic [PW_WIDTH-1:0] pw_q;
    logic [5:0]          len_q;
    logic [31:0]         cur_word;

    pw_md4_word #(.MAX_CHARS(MAX_CHARS)) u_word (
        .password (pw_q),
        .length   (len_q),
        .word_idx (w),
        .word     (cur_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            w         <= 4'd0;
            pw_q      <= '0;
            len_q     <= 6'd0;
            out_block <= '0;
            out_valid <= 1'b0;
            out_error <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pw_q      <= in_password;
                        len_q     <= in_length;
                        out_block <= '0;
                        w         <= 4'd0;
                        in_ready  <= 1'b0;
                        if (in_length > 6'(MAX_CHARS)) begin
                            out_error <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state     <= BUILD;
                        end
                    end
                end
                BUILD: begin
                    out_block[{w, 5'd0} +: 32] <= cur_word;
                    w <= w + 4'd1;
                    if (w == 4'd15) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Entry from the error path arrives with out_valid low, so
                    // out_ready only counts once out_valid is actually up.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_error <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_md4_block.sv
module tb_pw_md4_block;

    localparam int PW_W = 160;

    logic             clk = 1'b0;
    logic             reset;
    logic [PW_W-1:0]  in_password;
    logic [5:0]       in_length;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     out_block;
    logic             out_error;
    logic             out_valid;
    logic             out_ready;

    typedef struct {
        logic [511:0] blk;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pw_md4_block #(.MAX_CHARS(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_password (in_password),
        .in_length   (in_length),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_block   (out_block),
        .out_error   (out_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] model(input logic [PW_W-1:0] pw, input logic [5:0] len);
        logic [511:0] m;
        m = '0;
        if (len > 6'd20) return m;
        for (int i = 0; i < int'(len); i++)
            m[16*i +: 8] = pw[PW_W-1-8*i -: 8];
        m[16*int'(len) +: 8] = 8'h80;
        m[8*56 +: 16] = 16'(len) * 16'd16;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the transfer edge N.
    task automatic send(input logic [PW_W-1:0] pw, input logic [5:0] len);
        int n;
        exp_t e;
        e.blk = model(pw, len);
        e.err = (len > 6'd20);
        sb.push_back(e);
        in_password = pw;
        in_length   = len;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) chk("xfer_timeout", 512'(in_ready), 512'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold, input int exp_lat, input bit pulse);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (exp_lat >= 0) chk("latency", 512'(n), 512'(exp_lat));
        if (sb.size() == 0) begin
            chk("sb_empty", 512'(sb.size()), 512'd1);
            return;
        end
        e = sb.pop_front();
        chk("block", out_block, e.blk);
        chk("error", 512'(out_error), 512'(e.err));
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 2) begin
                in_password = {PW_W{1'b1}};
                in_length   = 6'd3;
                in_valid    = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            chk("hold_block", out_block, e.blk);
            chk("hold_valid", 512'(out_valid), 512'd1);
            chk("hold_in_ready", 512'(in_ready), 512'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_clr", 512'(out_valid), 512'd0);
        chk("error_clr", 512'(out_error), 512'd0);
        chk("in_ready_back", 512'(in_ready), 512'd1);
        chk("block_kept", out_block, e.blk);
    endtask

    initial begin
        logic [PW_W-1:0] pw;
        logic [5:0]      len;

        reset       = 1'b1;
        in_password = '0;
        in_length   = 6'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        step();
        step();
        chk("rst_block", out_block, 512'd0);
        chk("rst_valid", 512'(out_valid), 512'd0);
        chk("rst_error", 512'(out_error), 512'd0);
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        reset = 1'b0;
        step();

        // L=1, "a"
        pw = '0;
        pw[PW_W-1 -: 8] = 8'h61;
        send(pw, 6'd1);
        recv(0, 16, 1'b0);
        chk("l1_w0", 512'(out_block[31:0]), 512'h00800061);
        chk("l1_w14", 512'(out_block[14*32 +: 32]), 512'h00000010);

        // L=0, empty string
        send({PW_W{1'b1}}, 6'd0);
        recv(1, 16, 1'b0);
        chk("l0_w0", 512'(out_block[31:0]), 512'h00000080);
        chk("l0_rest", 512'(out_block[511:32]), 512'd0);

        // L=20, chars 0x41..0x54
        for (int i = 0; i < 20; i++) pw[PW_W-1-8*i -: 8] = 8'(8'h41 + i);
        send(pw, 6'd20);
        recv(0, 16, 1'b0);
        chk("l20_w0", 512'(out_block[31:0]), 512'h00420041);
        chk("l20_w9", 512'(out_block[9*32 +: 32]), 512'h00540053);
        chk("l20_w10", 512'(out_block[10*32 +: 32]), 512'h00000080);
        chk("l20_w14", 512'(out_block[14*32 +: 32]), 512'h00000140);

        // L=21 error path
        send(pw, 6'd21);
        recv(0, 1, 1'b0);
        chk("l21_block", out_block, 512'd0);

        // Backpressure with a stray in_valid pulse while busy
        pw = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send(pw, 6'd7);
        recv(5, 16, 1'b1);
        step();
        chk("no_stray_xfer", 512'(in_ready), 512'd1);

        // Reset in the middle of BUILD (w=7)
        send({$urandom, $urandom, $urandom, $urandom, $urandom}, 6'd15);
        repeat (7) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_block", out_block, 512'd0);
        chk("mid_rst_valid", 512'(out_valid), 512'd0);
        chk("mid_rst_error", 512'(out_error), 512'd0);
        chk("mid_rst_in_ready", 512'(in_ready), 512'd1);
        sb.delete();
        step();
        reset = 1'b0;
        step();
        pw = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send(pw, 6'd4);
        recv(0, 16, 1'b0);

        // Random legal and illegal lengths
        for (int t = 0; t < 8; t++) begin
            pw  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            len = 6'($urandom_range(0, 20));
            send(pw, len);
            recv($urandom_range(0, 3), 16, 1'b0);
        end
        send(pw, 6'd63);
        recv(2, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
